// File: rtl/beat_sequencer_if.sv
// beat_sequencer_if
//   Bundles the beat sequencer's control inputs and beat/status outputs.
//   master : front end / controller side (drives START, SW, cycle controls;
//            observes W, ST0, RUN, CYCLE_END, CYC_CNT)
//   slave  : the sequencer itself
interface beat_sequencer_if #(
    parameter int NBEATS = 3,
    parameter int SW_W   = 3,
    parameter int CNT_W  = 8
);
    logic              START;
    logic [SW_W-1:0]   SW;
    logic              SHORT;
    logic              LONG;
    logic              STOP;
    logic              SST0;
    logic [NBEATS-1:0] W;
    logic              ST0;
    logic              RUN;
    logic              CYCLE_END;
    logic [CNT_W-1:0]  CYC_CNT;

    modport master (
        output START, SW, SHORT, LONG, STOP, SST0,
        input  W, ST0, RUN, CYCLE_END, CYC_CNT
    );

    modport slave (
        input  START, SW, SHORT, LONG, STOP, SST0,
        output W, ST0, RUN, CYCLE_END, CYC_CNT
    );
endinterface

// File: rtl/beat_sequencer.sv
// beat_sequencer
//   Machine-cycle beat generator for the hardwired CPU controller. Steps a
//   one-hot beat vector W through a cycle of NORM_BEATS beats (NBEATS when
//   LONG is seen, one beat when SHORT is seen in W1), keeps the console
//   phase flag ST0 and counts completed cycles.
// Ports
//   T_clk_3 : beat clock, rising edge
//   CLR     : asynchronous reset, active low
//   bus     : slave modport of beat_sequencer_if
//             in  START, SW, SHORT, LONG, STOP, SST0
//             out W (one-hot beat, 0 when idle), ST0, RUN,
//                 CYCLE_END (combinational), CYC_CNT
module beat_sequencer #(
    parameter int NBEATS     = 3,
    parameter int NORM_BEATS = 2,
    parameter int SW_W       = 3,
    parameter int CNT_W      = 8
) (
    input  logic                  T_clk_3,
    input  logic                  CLR,
    beat_sequencer_if.slave       bus
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [NBEATS-1:0] W1 = NBEATS'(1);

    state_t            state;
    logic [NBEATS-1:0] w_q;
    logic              st0_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SW_W-1:0]   sw_q;
    logic              long_l, stop_l, sst0_l;

    logic w_onehot;
    logic long_any, stop_any, sst0_any;
    logic cycle_end;

    // Zero is not a legal beat while running, so it counts as corrupt too.
    assign w_onehot = (w_q != '0) && ((w_q & (w_q - W1)) == '0);

    // Controls act in the beat they arrive as well as being remembered.
    assign long_any = bus.LONG | long_l;
    assign stop_any = bus.STOP | stop_l;
    assign sst0_any = bus.SST0 | sst0_l;

    // SHORT only matters in W1; LONG suppresses the normal-length end but
    // never the final beat.
    assign cycle_end = (state == S_RUN) && w_onehot &&
                       ((w_q[0] & bus.SHORT) |
                        (w_q[NORM_BEATS-1] & ~long_any) |
                        w_q[NBEATS-1]);

    always_ff @(posedge T_clk_3 or negedge CLR) begin
        if (!CLR) begin
            state  <= S_IDLE;
            w_q    <= '0;
            st0_q  <= 1'b0;
            cnt_q  <= '0;
            sw_q   <= '0;
            long_l <= 1'b0;
            stop_l <= 1'b0;
            sst0_l <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    w_q <= '0;
                    if (bus.START) begin
                        state <= S_RUN;
                        w_q   <= W1;
                        sw_q  <= bus.SW;
                    end else if (bus.SW != sw_q) begin
                        // A console mode change restarts the console phase.
                        st0_q <= 1'b0;
                        sw_q  <= bus.SW;
                    end
                end
                S_RUN: begin
                    if (!w_onehot) begin
                        // Upset beat register: resynchronise on W1.
                        w_q    <= W1;
                        long_l <= long_any;
                        stop_l <= stop_any;
                        sst0_l <= sst0_any;
                    end else if (cycle_end) begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        long_l <= 1'b0;
                        stop_l <= 1'b0;
                        sst0_l <= 1'b0;
                        if (sst0_any)
                            st0_q <= 1'b1;
                        if (stop_any) begin
                            state <= S_IDLE;
                            w_q   <= '0;
                        end else begin
                            w_q   <= W1;
                        end
                    end else begin
                        w_q    <= {w_q[NBEATS-2:0], 1'b0};
                        long_l <= long_any;
                        stop_l <= stop_any;
                        sst0_l <= sst0_any;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    w_q   <= '0;
                end
            endcase
        end
    end

    assign bus.W         = w_q;
    assign bus.ST0       = st0_q;
    assign bus.RUN       = (state == S_RUN);
    assign bus.CYCLE_END = cycle_end;
    assign bus.CYC_CNT   = cnt_q;
endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer
//   Directed vector table for the documented beat sequences, hand-written
//   clear/wrap sequences, then random stimulus against a beat-index model.
module tb_beat_sequencer;
    localparam int NB   = 3;
    localparam int NORM = 2;
    localparam int SWW  = 3;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    beat_sequencer_if #(.NBEATS(NB), .SW_W(SWW), .CNT_W(CW)) bif ();

    beat_sequencer #(.NBEATS(NB), .NORM_BEATS(NORM), .SW_W(SWW), .CNT_W(CW)) dut (
        .T_clk_3 (clk),
        .CLR     (clr),
        .bus     (bif)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: beat index + flags ----------------
    bit m_run, m_st0, m_lg, m_sp, m_ss;
    int m_k, m_cnt;
    logic [SWW-1:0] m_swq;

    task automatic m_reset();
        m_run = 0; m_st0 = 0; m_lg = 0; m_sp = 0; m_ss = 0;
        m_k = 0; m_cnt = 0; m_swq = '0;
    endtask

    function automatic bit m_end(input bit sh, input bit lg);
        if (!m_run) return 1'b0;
        return (m_k == 0 && sh) || (m_k == NORM - 1 && !(lg || m_lg)) || (m_k == NB - 1);
    endfunction

    function automatic int m_w();
        return m_run ? (1 << m_k) : 0;
    endfunction

    task automatic m_step(input bit st, input logic [SWW-1:0] sw,
                          input bit sh, input bit lg, input bit sp, input bit ss);
        if (!m_run) begin
            if (st) begin
                m_run = 1; m_k = 0; m_swq = sw;
            end else if (sw != m_swq) begin
                m_st0 = 0; m_swq = sw;
            end
        end else if (m_end(sh, lg)) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            if (ss || m_ss) m_st0 = 1;
            if (sp || m_sp) m_run = 0;
            m_k = 0; m_lg = 0; m_sp = 0; m_ss = 0;
        end else begin
            m_k++;
            m_lg = m_lg | lg; m_sp = m_sp | sp; m_ss = m_ss | ss;
        end
    endtask

    // One clock: drive at negedge, sample CYCLE_END before the edge,
    // model advances with the DUT, outputs sampled 1ns after the edge.
    logic ce_act;
    bit   ce_mod;
    task automatic tick(input bit st, input logic [SWW-1:0] sw,
                        input bit sh, input bit lg, input bit sp, input bit ss);
        @(negedge clk);
        bif.START = st; bif.SW = sw; bif.SHORT = sh;
        bif.LONG = lg; bif.STOP = sp; bif.SST0 = ss;
        #1;
        ce_act = bif.CYCLE_END;
        ce_mod = m_end(sh, lg);
        @(posedge clk);
        m_step(st, sw, sh, lg, sp, ss);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        m_reset();
        #2;
        @(negedge clk);
        clr = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit st; logic [SWW-1:0] sw; bit sh, lg, sp, ss;
        bit ce; logic [NB-1:0] w; bit run, st0; int cnt;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit st, logic [SWW-1:0] sw, bit sh, bit lg, bit sp, bit ss,
                                bit ce, logic [NB-1:0] w, bit run, bit st0, int cnt);
        vec_t v;
        v.st = st; v.sw = sw; v.sh = sh; v.lg = lg; v.sp = sp; v.ss = ss;
        v.ce = ce; v.w = w; v.run = run; v.st0 = st0; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        bif.START = 0; bif.SW = '0; bif.SHORT = 0;
        bif.LONG = 0; bif.STOP = 0; bif.SST0 = 0;
        m_reset();

        //            st sw     sh lg sp ss   ce w       run st0 cnt
        // plain two-beat cycles
        tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 3'b001, 1, 0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b010, 1, 0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 1, 3'b001, 1, 0, 1));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b010, 1, 0, 1));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 1, 3'b001, 1, 0, 2));
        // LONG in W2, then back to two beats
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b010, 1, 0, 2));
        tbl.push_back(mk(0, 3'b000, 0, 1, 0, 0, 0, 3'b100, 1, 0, 2));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 1, 3'b001, 1, 0, 3));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b010, 1, 0, 3));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 1, 3'b001, 1, 0, 4));
        // LONG seen in W1 is remembered into W2
        tbl.push_back(mk(0, 3'b000, 0, 1, 0, 0, 0, 3'b010, 1, 0, 4));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b100, 1, 0, 4));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 1, 3'b001, 1, 0, 5));
        // SHORT in W1 holds W1; SHORT beats LONG
        tbl.push_back(mk(0, 3'b000, 1, 0, 0, 0, 1, 3'b001, 1, 0, 6));
        tbl.push_back(mk(0, 3'b000, 1, 0, 0, 0, 1, 3'b001, 1, 0, 7));
        tbl.push_back(mk(0, 3'b000, 1, 1, 0, 0, 1, 3'b001, 1, 0, 8));
        // SHORT outside W1 is ignored
        tbl.push_back(mk(0, 3'b000, 0, 1, 0, 0, 0, 3'b010, 1, 0, 8));
        tbl.push_back(mk(0, 3'b000, 1, 0, 0, 0, 0, 3'b100, 1, 0, 8));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 1, 3'b001, 1, 0, 9));
        // STOP in W1 finishes the cycle then idles; START restarts
        tbl.push_back(mk(0, 3'b000, 0, 0, 1, 0, 0, 3'b010, 1, 0, 9));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 1, 3'b000, 0, 0, 10));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 0, 0, 10));
        tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 3'b001, 1, 0, 10));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b010, 1, 0, 10));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 1, 3'b001, 1, 0, 11));
        // SST0 sets ST0 at cycle end, ST0 survives STOP and restart
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 1, 0, 3'b010, 1, 0, 11));
        tbl.push_back(mk(0, 3'b000, 0, 0, 1, 0, 1, 3'b000, 0, 1, 12));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 0, 1, 12));
        tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 3'b001, 1, 1, 12));
        tbl.push_back(mk(0, 3'b000, 0, 0, 1, 0, 0, 3'b010, 1, 1, 12));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 1, 3'b000, 0, 1, 13));
        // idle mode change clears ST0
        tbl.push_back(mk(0, 3'b101, 0, 0, 0, 0, 0, 3'b000, 0, 0, 13));
        tbl.push_back(mk(0, 3'b101, 0, 0, 0, 0, 0, 3'b000, 0, 0, 13));
        // START while running and SW change while running are ignored
        tbl.push_back(mk(1, 3'b101, 0, 0, 0, 0, 0, 3'b001, 1, 0, 13));
        tbl.push_back(mk(1, 3'b101, 0, 0, 0, 1, 0, 3'b010, 1, 0, 13));
        tbl.push_back(mk(0, 3'b010, 0, 0, 0, 0, 1, 3'b001, 1, 1, 14));
        tbl.push_back(mk(0, 3'b010, 0, 0, 1, 0, 0, 3'b010, 1, 1, 14));
        tbl.push_back(mk(0, 3'b010, 0, 0, 0, 0, 1, 3'b000, 0, 1, 15));
        tbl.push_back(mk(0, 3'b010, 0, 0, 0, 0, 0, 3'b000, 0, 0, 15));

        // reset state
        #12;
        chk("reset_W",   bif.W,       0);
        chk("reset_RUN", bif.RUN,     0);
        chk("reset_ST0", bif.ST0,     0);
        chk("reset_CNT", bif.CYC_CNT, 0);
        chk("reset_CE",  bif.CYCLE_END, 0);
        @(negedge clk);
        clr = 1'b1;

        foreach (tbl[i]) begin
            tick(tbl[i].st, tbl[i].sw, tbl[i].sh, tbl[i].lg, tbl[i].sp, tbl[i].ss);
            chk($sformatf("vec%0d_CE", i),  ce_act,      tbl[i].ce);
            chk($sformatf("vec%0d_W", i),   bif.W,       tbl[i].w);
            chk($sformatf("vec%0d_RUN", i), bif.RUN,     tbl[i].run);
            chk($sformatf("vec%0d_ST0", i), bif.ST0,     tbl[i].st0);
            chk($sformatf("vec%0d_CNT", i), bif.CYC_CNT, tbl[i].cnt);
        end

        // CLR mid-W2 with CYC_CNT at 255 clears everything immediately
        do_reset();
        tick(1, 3'b000, 0, 0, 0, 0);
        tick(0, 3'b000, 0, 0, 0, 1);
        tick(0, 3'b000, 0, 0, 0, 0);
        for (int c = 0; c < 254; c++) begin
            tick(0, 3'b000, 0, 0, 0, 0);
            tick(0, 3'b000, 0, 0, 0, 0);
        end
        chk("pre_clr_CNT", bif.CYC_CNT, 255);
        chk("pre_clr_ST0", bif.ST0, 1);
        tick(0, 3'b000, 0, 0, 0, 0);
        chk("pre_clr_W", bif.W, 3'b010);
        @(negedge clk);
        #2;
        clr = 1'b0;
        m_reset();
        #1;
        chk("clr_W",   bif.W,       0);
        chk("clr_RUN", bif.RUN,     0);
        chk("clr_ST0", bif.ST0,     0);
        chk("clr_CNT", bif.CYC_CNT, 0);
        chk("clr_CE",  bif.CYCLE_END, 0);
        @(negedge clk);
        clr = 1'b1;

        // counter wrap 255 -> 0
        tick(1, 3'b000, 0, 0, 0, 0);
        for (int c = 0; c < 255; c++) begin
            tick(0, 3'b000, 0, 0, 0, 0);
            tick(0, 3'b000, 0, 0, 0, 0);
        end
        chk("wrap_CNT255", bif.CYC_CNT, 255);
        tick(0, 3'b000, 0, 0, 0, 0);
        tick(0, 3'b000, 0, 0, 0, 0);
        chk("wrap_CNT0", bif.CYC_CNT, 0);
        chk("wrap_W",    bif.W, 3'b001);
        chk("wrap_RUN",  bif.RUN, 1);

        // random stimulus against the model
        do_reset();
        begin
            logic [SWW-1:0] sw_r;
            sw_r = '0;
            for (int i = 0; i < 3000; i++) begin
                bit st, sh, lg, sp, ss;
                st = ($urandom % 3) == 0;
                sh = ($urandom % 4) == 0;
                lg = ($urandom % 4) == 0;
                sp = ($urandom % 6) == 0;
                ss = ($urandom % 8) == 0;
                if (($urandom % 8) == 0) sw_r = SWW'($urandom);
                tick(st, sw_r, sh, lg, sp, ss);
                chk("rnd_CE",  ce_act,      ce_mod);
                chk("rnd_W",   bif.W,       m_w());
                chk("rnd_RUN", bif.RUN,     m_run);
                chk("rnd_ST0", bif.ST0,     m_st0);
                chk("rnd_CNT", bif.CYC_CNT, m_cnt);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
